// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: derives a per-frame tick from v_sync, runs the
// idle/serve/play/point/game-over flow, keeps scores and gates paddle steps.
module pong_game_ctrl #(
    parameter int WIN_SCORE        = 9,
    parameter int SERVE_FRAMES     = 60,
    parameter int POINT_FRAMES     = 30,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       v_sync,
    input  logic       start,
    input  logic       clear_score,
    input  logic       up_L,
    input  logic       down_L,
    input  logic       up_R,
    input  logic       down_R,
    input  logic       miss_L,
    input  logic       miss_R,
    output logic       frame_tick,
    output logic [2:0] state,
    output logic       ball_reset,
    output logic       ball_enable,
    output logic       serve_dir,
    output logic       step_up_L,
    output logic       step_dn_L,
    output logic       step_up_R,
    output logic       step_dn_R,
    output logic [3:0] score_L,
    output logic [3:0] score_R,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q;
    logic [3:0]       score_l_d, score_r_d;
    logic             dir_d;
    logic             vs_d;
    logic             vs_act, vs_d_act, tick_d, in_move, count_tick;

    // Normalise polarity so "1" always means v_sync asserted.
    assign vs_act   = v_sync ^ VSYNC_ACTIVE_LOW;
    assign vs_d_act = vs_d ^ VSYNC_ACTIVE_LOW;
    assign tick_d   = vs_act & ~vs_d_act;
    assign in_move  = (state_q == SERVE) || (state_q == PLAY);

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            vs_d       <= VSYNC_ACTIVE_LOW;
            frame_tick <= 1'b0;
            step_up_L  <= 1'b0;
            step_dn_L  <= 1'b0;
            step_up_R  <= 1'b0;
            step_dn_R  <= 1'b0;
        end else begin
            vs_d       <= v_sync;
            frame_tick <= tick_d;
            step_up_L  <= tick_d & in_move & up_L & ~down_L;
            step_dn_L  <= tick_d & in_move & down_L & ~up_L;
            step_up_R  <= tick_d & in_move & up_R & ~down_R;
            step_dn_R  <= tick_d & in_move & down_R & ~up_R;
        end
    end

    // A tick landing on the first cycle of a state is not counted.
    assign count_tick = frame_tick & ~first_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_l_d = score_L;
        score_r_d = score_R;
        dir_d     = serve_dir;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SERVE;
                    dir_d   = 1'b1;
                end
            end
            SERVE: begin
                if (count_tick) begin
                    if (cnt_q == SERVE_LAST) state_d = PLAY;
                    else                     cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PLAY: begin
                if (miss_L && miss_R) begin
                    state_d = SERVE;
                end else if (miss_L) begin
                    score_r_d = score_R + 4'd1;
                    dir_d     = 1'b0;
                    state_d   = POINT;
                end else if (miss_R) begin
                    score_l_d = score_L + 4'd1;
                    dir_d     = 1'b1;
                    state_d   = POINT;
                end
            end
            POINT: begin
                if (count_tick) begin
                    if (cnt_q == POINT_LAST)
                        state_d = (score_L == WIN || score_R == WIN) ? GAME_OVER : SERVE;
                    else
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAME_OVER: begin
                if (start) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    dir_d     = 1'b1;
                    state_d   = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_score) begin
            state_d   = IDLE;
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            dir_d     = 1'b1;
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            score_L    <= 4'd0;
            score_R    <= 4'd0;
            serve_dir  <= 1'b1;
            ball_reset <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= (state_d != state_q);
            score_L    <= score_l_d;
            score_R    <= score_r_d;
            serve_dir  <= dir_d;
            ball_reset <= (state_d == SERVE) && (state_q != SERVE);
        end
    end

    assign state       = state_q;
    assign ball_enable = (state_q == PLAY);
    assign game_over   = (state_q == GAME_OVER);
    assign winner      = (state_q == GAME_OVER) && (score_R == WIN);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a per-cycle behavioural model of the game rules
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pong_game_ctrl;

    localparam int WIN   = 9;
    localparam int SERVE = 60;
    localparam int POINT = 30;
    localparam bit VSL   = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic v_sync = 1'b1;
    logic start = 1'b0, clear_score = 1'b0;
    logic up_L = 1'b0, down_L = 1'b0, up_R = 1'b0, down_R = 1'b0;
    logic miss_L = 1'b0, miss_R = 1'b0;

    logic       frame_tick, ball_reset, ball_enable, serve_dir, game_over, winner;
    logic [2:0] state;
    logic       step_up_L, step_dn_L, step_up_R, step_dn_R;
    logic [3:0] score_L, score_R;

    int checks = 0;
    int failures = 0;
    int vs_period = 1000;
    int vs_low = 100;

    pong_game_ctrl #(
        .WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT), .VSYNC_ACTIVE_LOW(VSL)
    ) dut (
        .pixel_clk(clk), .reset(reset), .v_sync(v_sync), .start(start),
        .clear_score(clear_score), .up_L(up_L), .down_L(down_L), .up_R(up_R),
        .down_R(down_R), .miss_L(miss_L), .miss_R(miss_R), .frame_tick(frame_tick),
        .state(state), .ball_reset(ball_reset), .ball_enable(ball_enable),
        .serve_dir(serve_dir), .step_up_L(step_up_L), .step_dn_L(step_dn_L),
        .step_up_R(step_up_R), .step_dn_R(step_dn_R), .score_L(score_L),
        .score_R(score_R), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // v_sync source: inactive-high for (period-low) cycles, then low pulse.
    initial begin
        forever begin
            repeat (vs_period - vs_low) @(negedge clk);
            v_sync = 1'b0;
            repeat (vs_low) @(negedge clk);
            v_sync = 1'b1;
        end
    end

    // Game-rule model: named phases, ticks counted since the state was entered.
    int       m_state, m_cyc, m_ticks;
    bit [3:0] m_sl, m_sr;
    bit       m_dir, m_tick, m_prev_act, m_brst, m_valid = 1'b0;
    bit       m_sul, m_sdl, m_sur, m_sdr;

    always @(posedge clk) begin : model
        int       ns;
        bit [3:0] sl, sr;
        bit       dir, act, counted, edge_now, mv;
        act = VSL ? !v_sync : v_sync;
        if (reset) begin
            m_valid <= 1'b1; m_state <= 0; m_sl <= 4'd0; m_sr <= 4'd0; m_dir <= 1'b1;
            m_prev_act <= 1'b0; m_tick <= 1'b0; m_brst <= 1'b0; m_cyc <= 0; m_ticks <= 0;
            m_sul <= 1'b0; m_sdl <= 1'b0; m_sur <= 1'b0; m_sdr <= 1'b0;
        end else begin
            ns = m_state; sl = m_sl; sr = m_sr; dir = m_dir;
            counted = m_tick && (m_cyc > 0);
            case (m_state)
                0: if (start) begin ns = 1; dir = 1'b1; end
                1: if (counted && m_ticks + 1 == SERVE) ns = 2;
                2: begin
                    if (miss_L && miss_R) ns = 1;
                    else if (miss_L) begin sr = sr + 4'd1; dir = 1'b0; ns = 3; end
                    else if (miss_R) begin sl = sl + 4'd1; dir = 1'b1; ns = 3; end
                end
                3: if (counted && m_ticks + 1 == POINT) ns = (sl == WIN || sr == WIN) ? 4 : 1;
                4: if (start) begin sl = 4'd0; sr = 4'd0; dir = 1'b1; ns = 1; end
                default: ns = 0;
            endcase
            if (clear_score) begin ns = 0; sl = 4'd0; sr = 4'd0; dir = 1'b1; end
            edge_now = act && !m_prev_act;
            mv = (m_state == 1) || (m_state == 2);
            m_tick <= edge_now;
            m_prev_act <= act;
            m_sul <= edge_now && mv && up_L && !down_L;
            m_sdl <= edge_now && mv && down_L && !up_L;
            m_sur <= edge_now && mv && up_R && !down_R;
            m_sdr <= edge_now && mv && down_R && !up_R;
            if (ns != m_state) begin m_cyc <= 0; m_ticks <= 0; end
            else begin m_cyc <= m_cyc + 1; m_ticks <= m_ticks + (counted ? 1 : 0); end
            m_brst <= (ns == 1) && (m_state != 1);
            m_state <= ns; m_sl <= sl; m_sr <= sr; m_dir <= dir;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_state", state, m_state);
            chk("m_frame_tick", frame_tick, m_tick);
            chk("m_ball_reset", ball_reset, m_brst);
            chk("m_ball_enable", ball_enable, m_state == 2);
            chk("m_game_over", game_over, m_state == 4);
            chk("m_serve_dir", serve_dir, m_dir);
            chk("m_score_L", score_L, m_sl);
            chk("m_score_R", score_R, m_sr);
            chk("m_step_up_L", step_up_L, m_sul);
            chk("m_step_dn_L", step_dn_L, m_sdl);
            chk("m_step_up_R", step_up_R, m_sur);
            chk("m_step_dn_R", step_dn_R, m_sdr);
            if (m_state == 4) chk("m_winner", winner, m_sr == WIN);
        end
    end

    // Runs until state==tgt, counting counted ticks spent in cnt_st and ball_reset pulses.
    task automatic run_to(input int tgt, input int cnt_st, input bit skip_first,
                          input int max_cyc, output int ticks, output int brst);
        int n;
        bit first;
        ticks = 0; brst = 0; n = 0; first = skip_first;
        while (state != 3'(tgt) && n < max_cyc) begin
            if (state == 3'(cnt_st) && frame_tick && !first) ticks++;
            if (ball_reset) brst++;
            first = 1'b0;
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_state_%0d", tgt), state, tgt);
    endtask

    task automatic pulse(input int which);
        if (which == 0) start = 1'b1;
        if (which == 1) miss_L = 1'b1;
        if (which == 2) miss_R = 1'b1;
        if (which == 3) begin miss_L = 1'b1; miss_R = 1'b1; end
        if (which == 4) clear_score = 1'b1;
        @(negedge clk);
        start = 1'b0; miss_L = 1'b0; miss_R = 1'b0; clear_score = 1'b0;
    endtask

    task automatic point_then_play(input int exp_sl, input int exp_sr, input int exp_dir);
        int t, b;
        chk("pt_state", state, 3);
        chk("pt_score_L", score_L, exp_sl);
        chk("pt_score_R", score_R, exp_sr);
        chk("pt_serve_dir", serve_dir, exp_dir);
        run_to(1, 3, 1'b1, 2000, t, b);
        chk("point_ticks", t, POINT);
        chk("reserve_ball_reset", ball_reset, 1);
        run_to(2, 1, 1'b1, 3000, t, b);
        chk("serve_ticks", t, SERVE);
    endtask

    int t, b, n_ft, n_a, n_b, n_c, n_d;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_score_L", score_L, 0);
        chk("rst_score_R", score_R, 0);
        chk("rst_serve_dir", serve_dir, 1);
        chk("rst_winner", winner, 0);
        chk("rst_frame_tick", frame_tick, 0);
        reset = 1'b0;

        // IDLE at 1000-cycle frames: two ticks per 2000 cycles, steps suppressed.
        up_L = 1'b1; down_R = 1'b1;
        n_ft = 0; n_a = 0;
        repeat (2000) begin
            @(negedge clk);
            n_ft += frame_tick;
            n_a += step_up_L + step_dn_R;
        end
        chk("idle_ticks", n_ft, 2);
        chk("idle_steps", n_a, 0);
        up_L = 1'b0; down_R = 1'b0;
        vs_period = 20; vs_low = 5;
        repeat (40) @(negedge clk);

        pulse(0);
        chk("serve_state", state, 1);
        chk("serve_ball_reset", ball_reset, 1);
        run_to(2, 1, 1'b1, 3000, t, b);
        chk("first_serve_ticks", t, SERVE);
        chk("first_serve_resets", b, 1);
        chk("play_ball_enable", ball_enable, 1);

        // Paddle steps follow frame ticks; both buttons of a side cancel.
        up_L = 1'b1; down_R = 1'b1;
        n_ft = 0; n_a = 0; n_b = 0; n_c = 0;
        repeat (100) begin
            @(negedge clk);
            n_ft += frame_tick;
            n_a += step_up_L; n_b += step_dn_R; n_c += step_dn_L + step_up_R;
        end
        chk("play_ticks_100", n_ft, 5);
        chk("step_up_L_count", n_a, 5);
        chk("step_dn_R_count", n_b, 5);
        chk("other_steps", n_c, 0);
        down_R = 1'b0; down_L = 1'b1;
        n_d = 0;
        repeat (60) begin
            @(negedge clk);
            n_d += step_up_L + step_dn_L;
        end
        chk("both_buttons_steps", n_d, 0);
        up_L = 1'b0; down_L = 1'b0;

        pulse(2);
        point_then_play(1, 0, 1);
        pulse(1);
        point_then_play(1, 1, 0);

        pulse(3);
        chk("replay_state", state, 1);
        chk("replay_ball_reset", ball_reset, 1);
        chk("replay_score_L", score_L, 1);
        chk("replay_score_R", score_R, 1);
        chk("replay_dir", serve_dir, 0);
        run_to(2, 1, 1'b1, 3000, t, b);

        for (int r = 2; r <= 8; r++) begin
            pulse(1);
            point_then_play(1, r, 0);
        end
        pulse(1);
        pulse(2);
        chk("miss_in_point_ignored", score_L, 1);
        run_to(4, 3, 1'b0, 2000, t, b);
        chk("go_game_over", game_over, 1);
        chk("go_winner", winner, 1);
        chk("go_score_R", score_R, 9);
        chk("go_ball_enable", ball_enable, 0);

        start = 1'b1;
        @(negedge clk);
        chk("restart_state", state, 1);
        chk("restart_score_L", score_L, 0);
        chk("restart_score_R", score_R, 0);
        chk("restart_dir", serve_dir, 1);
        repeat (4) @(negedge clk);
        chk("start_held_in_serve", state, 1);
        start = 1'b0;
        run_to(2, 1, 1'b0, 3000, t, b);

        pulse(2);
        point_then_play(1, 0, 1);
        pulse(4);
        chk("clear_state", state, 0);
        chk("clear_score_L", score_L, 0);
        chk("clear_dir", serve_dir, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
